// File: rtl/feature_loader.sv
// feature_loader: byte-serial front end of the decision-tree classifier.
// Collects one N_FEAT-byte frame, keeps the bytes the tree uses (X0, X1,
// X4, X5, X6) in a shadow buffer and commits them to the output registers
// in a single edge. A one-cycle COMMIT bubble follows each frame.
// Optional feature: define FEATURE_LOADER_TIMEOUT_EN to abandon a frame
// after TIMEOUT consecutive idle cycles inside it.
module feature_loader #(
  parameter int N_FEAT  = 7,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic [7:0] X0,
  output logic [7:0] X1,
  output logic [7:0] X4,
  output logic [7:0] X5,
  output logic [7:0] X6,
  output logic       vec_valid,
  output logic       busy,
  output logic       err
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t            state;
  logic [2:0]        idx;
  logic [DATA_W-1:0] sh_x0_p0;
  logic [DATA_W-1:0] sh_x1_p0;
  logic [DATA_W-1:0] sh_x4_p0;
  logic [DATA_W-1:0] sh_x5_p0;
  logic              accept;
  logic              last_beat;

  assign accept    = in_valid && in_ready;
  assign last_beat = (idx == 3'(N_FEAT - 1));

`ifdef FEATURE_LOADER_TIMEOUT_EN
  // gap counts idle cycles inside a frame; hitting GAP_LAST on an idle
  // edge means this is the TIMEOUT-th idle cycle.
  localparam logic [7:0] GAP_LAST = 8'(TIMEOUT - 1);
  logic [7:0] gap;
`else
  // Without the gap counter TIMEOUT has no effect.
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT > 0);
`endif

  // Shadow capture of the tree features; holds data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept && in_sof) begin
      sh_x0_p0 <= in_data;
    end else if (accept && state == LOAD) begin
      case (idx)
        3'd1:    sh_x1_p0 <= in_data;
        3'd4:    sh_x4_p0 <= in_data;
        3'd5:    sh_x5_p0 <= in_data;
        default: ;
      endcase
    end
  end

  // Frame FSM with registered handshake, status pulses and output commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      vec_valid <= 1'b0;
      X0        <= '0;
      X1        <= '0;
      X4        <= '0;
      X5        <= '0;
      X6        <= '0;
`ifdef FEATURE_LOADER_TIMEOUT_EN
      gap       <= 8'd0;
`endif
    end else begin
      err       <= 1'b0;
      vec_valid <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (in_sof) begin
              idx   <= 3'd1;
              busy  <= 1'b1;
              state <= LOAD;
`ifdef FEATURE_LOADER_TIMEOUT_EN
              gap   <= 8'd0;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
`ifdef FEATURE_LOADER_TIMEOUT_EN
            gap <= 8'd0;
`endif
            if (in_sof) begin
              // Premature restart: this beat is byte 0 of a new frame.
              err <= 1'b1;
              idx <= 3'd1;
            end else if (last_beat) begin
              X0        <= sh_x0_p0;
              X1        <= sh_x1_p0;
              X4        <= sh_x4_p0;
              X5        <= sh_x5_p0;
              X6        <= in_data;
              vec_valid <= 1'b1;
              in_ready  <= 1'b0;
              busy      <= 1'b0;
              idx       <= 3'd0;
              state     <= COMMIT;
            end else begin
              idx <= idx + 3'd1;
            end
          end
`ifdef FEATURE_LOADER_TIMEOUT_EN
          else if (gap == GAP_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            idx   <= 3'd0;
            gap   <= 8'd0;
            state <= IDLE;
          end else begin
            gap <= gap + 8'd1;
          end
`endif
        end
        COMMIT: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          idx      <= 3'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feature_loader.sv
// tb_feature_loader: directed and randomized checks of feature_loader
// against a frame-level reference model (a byte queue per frame).
module tb_feature_loader;

  localparam int TIMEOUT = 15;
  localparam int NF      = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sof;
  logic       in_ready;
  logic [7:0] X0, X1, X4, X5, X6;
  logic       vec_valid;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] frame_q[$];
  logic [7:0] m_x[5];
  logic       m_ready;
  logic       m_vv;
  logic       m_err;
  int         idle;

  feature_loader #(.N_FEAT(NF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_ready(in_ready), .X0(X0), .X1(X1), .X4(X4),
    .X5(X5), .X6(X6), .vec_valid(vec_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    foreach (m_x[i]) m_x[i] = 8'h00;
    m_ready = 1'b0;
    m_vv    = 1'b0;
    m_err   = 1'b0;
    idle    = 0;
  endtask

  task automatic check_outputs();
    chk("X0", X0, m_x[0]);
    chk("X1", X1, m_x[1]);
    chk("X4", X4, m_x[2]);
    chk("X5", X5, m_x[3]);
    chk("X6", X6, m_x[4]);
    chk("vec_valid", vec_valid, m_vv);
    chk("err", err, m_err);
    chk("busy", busy, frame_q.size() != 0);
  endtask

  // One clock cycle with the given inputs; model advances, outputs checked.
  task automatic cycle(input logic v, input logic s, input logic [7:0] d, output logic acc);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    #1;
    chk("in_ready", in_ready, m_ready);
    acc   = v && m_ready;
    m_vv  = 1'b0;
    m_err = 1'b0;
    if (acc) begin
      idle = 0;
      if (s) begin
        if (frame_q.size() != 0) m_err = 1'b1;
        frame_q.delete();
        frame_q.push_back(d);
      end else if (frame_q.size() == 0) begin
        m_err = 1'b1;
      end else begin
        frame_q.push_back(d);
        if (frame_q.size() == NF) begin
          m_x[0] = frame_q[0];
          m_x[1] = frame_q[1];
          m_x[2] = frame_q[4];
          m_x[3] = frame_q[5];
          m_x[4] = frame_q[6];
          m_vv   = 1'b1;
          frame_q.delete();
        end
      end
    end
`ifdef FEATURE_LOADER_TIMEOUT_EN
    else if (frame_q.size() != 0) begin
      idle++;
      if (idle == TIMEOUT) begin
        m_err = 1'b1;
        frame_q.delete();
        idle = 0;
      end
    end
`endif
    m_ready = !m_vv;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Present a beat and hold it until accepted (bounded).
  task automatic send(input logic s, input logic [7:0] d);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 8) begin
      cycle(1'b1, s, d, acc);
      n++;
    end
    chk("send_accept", acc, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    logic a;
    repeat (n) cycle(1'b0, 1'b0, 8'h00, a);
  endtask

  initial begin
    logic       a;
    logic [7:0] b;
    int         stalls;

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;

    // Single frame 11..77
    for (int i = 0; i < NF; i++) send(i == 0, 8'(11 * (i + 1)));
    chk("f1_X0", X0, 8'd11);
    chk("f1_X1", X1, 8'd22);
    chk("f1_X4", X4, 8'd55);
    chk("f1_X5", X5, 8'd66);
    chk("f1_X6", X6, 8'd77);
    chk("f1_vec_valid", vec_valid, 1'b1);
    chk("f1_in_ready", in_ready, 1'b0);
    idle_cycles(2);

    // Two back-to-back frames with in_valid held high; count the stall
    stalls = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NF; i++) begin
        b = 8'($urandom);
        cycle(1'b1, i == 0, b, a);
        while (!a && stalls < 4) begin
          stalls++;
          cycle(1'b1, i == 0, b, a);
        end
      end
    end
    chk("b2b_stalls", stalls, 1);
    idle_cycles(1);

    // Beat without sof in IDLE
    cycle(1'b1, 1'b0, 8'h5A, a);
    chk("nosof_err", err, 1'b1);
    chk("nosof_busy", busy, 1'b0);
    idle_cycles(2);

    // Restart after 3 bytes, then frame 1..7
    send(1'b1, 8'hA1); send(1'b0, 8'hA2); send(1'b0, 8'hA3);
    send(1'b1, 8'd1);
    chk("restart_err", err, 1'b1);
    for (int i = 2; i <= NF; i++) send(1'b0, 8'(i));
    chk("rs_X0", X0, 8'd1);
    chk("rs_X1", X1, 8'd2);
    chk("rs_X4", X4, 8'd5);
    chk("rs_X5", X5, 8'd6);
    chk("rs_X6", X6, 8'd7);
    idle_cycles(1);

`ifdef FEATURE_LOADER_TIMEOUT_EN
    // Timeout after 4 bytes, then a beat landing on gap cycle 15
    for (int i = 0; i < 4; i++) send(i == 0, 8'(8'hC0 + i));
    idle_cycles(TIMEOUT);
    chk("to_err", err, 1'b1);
    chk("to_busy", busy, 1'b0);
    idle_cycles(2);
    for (int i = 0; i < 4; i++) send(i == 0, 8'(8'hD0 + i));
    idle_cycles(TIMEOUT - 1);
    send(1'b0, 8'hD4);
    chk("nto_err", err, 1'b0);
    chk("nto_busy", busy, 1'b1);
    send(1'b0, 8'hD5); send(1'b0, 8'hD6);
    chk("nto_X6", X6, 8'hD6);
`else
    // Long stall inside a frame never aborts it
    for (int i = 0; i < 4; i++) send(i == 0, 8'(8'hC0 + i));
    idle_cycles(40);
    chk("stall_busy", busy, 1'b1);
    send(1'b0, 8'hC4); send(1'b0, 8'hC5); send(1'b0, 8'hC6);
    chk("stall_X6", X6, 8'hC6);
`endif
    idle_cycles(1);

    // Asynchronous reset mid-frame after a commit
    for (int i = 0; i < NF; i++) send(i == 0, 8'(8'h30 + i));
    send(1'b1, 8'h91); send(1'b0, 8'h92); send(1'b0, 8'h93);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_X0", X0, 8'h00);
    chk("ar_X6", X6, 8'h00);
    chk("ar_vec_valid", vec_valid, 1'b0);
    chk("ar_in_ready", in_ready, 1'b0);
    chk("ar_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < NF; i++) send(i == 0, 8'(8'h60 + i));
    chk("ar_fresh_X4", X4, 8'h64);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 8'($urandom), a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
